// File: rtl/pq_ctrl_pkg.sv
// Shared types and defaults for the priority-queue arbiter slice.
package pq_ctrl_pkg;

    localparam int unsigned PQ_DEF_W         = 16;
    localparam int unsigned PQ_DEF_NUM_REQ   = 4;
    localparam int unsigned PQ_DEF_DEPTH     = 64;
    localparam int unsigned PQ_DEF_POP_BURST = 4;

    localparam logic PQ_PUSH = 1'b1;
    localparam logic PQ_POP  = 1'b0;

    typedef enum logic [2:0] {
        StBoot,
        StIdle,
        StIssue,
        StExec,
        StDone
    } pq_state_e;

endpackage

// File: rtl/pq_arbiter_if.sv
// Command/response bus between the arbiter (master) and the priority queue (slave).
interface pq_arbiter_if
    import pq_ctrl_pkg::*;
#(
    parameter int unsigned W = PQ_DEF_W
) ();

    logic         pq_op_en;
    logic         pq_opcode;
    logic [W-1:0] pq_vertex;
    logic [W-1:0] pq_prev_vertex;
    logic [W-1:0] pq_dist;
    logic [15:0]  pq_queue_length;
    logic [W-1:0] pq_discard_vertex;
    logic [W-1:0] pq_discard_prev;
    logic [W-1:0] pq_discard_dist;

    modport master (
        output pq_op_en,
        output pq_opcode,
        output pq_vertex,
        output pq_prev_vertex,
        output pq_dist,
        input  pq_queue_length,
        input  pq_discard_vertex,
        input  pq_discard_prev,
        input  pq_discard_dist
    );

    modport slave (
        input  pq_op_en,
        input  pq_opcode,
        input  pq_vertex,
        input  pq_prev_vertex,
        input  pq_dist,
        output pq_queue_length,
        output pq_discard_vertex,
        output pq_discard_prev,
        output pq_discard_dist
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter
    import pq_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ = PQ_DEF_NUM_REQ,
    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IdxW-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IdxW-1:0]    idx
);

    logic            found;
    logic [IdxW-1:0] pos;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            pos = IdxW'((32'(ptr) + i) % NUM_REQ);
            if (!found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/pq_arbiter.sv
// Arbitrates one pop client and NUM_REQ round-robin push clients onto a single
// priority queue; each queued operation takes IDLE->ISSUE->EXEC->DONE.
module pq_arbiter
    import pq_ctrl_pkg::*;
#(
    parameter int unsigned W         = PQ_DEF_W,
    parameter int unsigned NUM_REQ   = PQ_DEF_NUM_REQ,
    parameter int unsigned DEPTH     = PQ_DEF_DEPTH,
    parameter int unsigned POP_BURST = PQ_DEF_POP_BURST
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   push_req,
    input  logic [NUM_REQ*W-1:0] push_vertex,
    input  logic [NUM_REQ*W-1:0] push_prev,
    input  logic [NUM_REQ*W-1:0] push_dist,
    output logic [NUM_REQ-1:0]   push_gnt,
    input  logic                 pop_req,
    output logic                 pop_gnt,
    output logic                 pop_valid,
    output logic                 pop_empty,
    output logic [W-1:0]         pop_vertex,
    output logic [W-1:0]         pop_prev,
    output logic [W-1:0]         pop_dist,
    pq_arbiter_if.master         pq,
    output logic                 busy,
    output logic                 full,
    output logic                 overflow_err,
    input  logic                 err_clr
);

    localparam int unsigned IdxW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CntW      = $clog2(POP_BURST + 1);
    localparam logic [CntW-1:0] BurstMax = CntW'(POP_BURST);
    localparam logic [IdxW-1:0] LastIdx  = IdxW'(NUM_REQ - 1);
    localparam logic [15:0]     DepthLen = 16'(DEPTH);

    pq_state_e        state_q;
    logic [IdxW-1:0]  rr_ptr_q;
    logic [CntW-1:0]  pop_cnt_q;
    logic             is_pop_q;

    logic [NUM_REQ-1:0] push_elig;
    logic [NUM_REQ-1:0] rr_gnt;
    logic [IdxW-1:0]    rr_idx;
    logic               push_any;
    logic               sel_pop;
    logic               sel_push;

    assign full      = (pq.pq_queue_length >= DepthLen);
    assign busy      = (state_q != StIdle);
    assign push_elig = full ? '0 : push_req;
    assign push_any  = |push_elig;

    // pop_gnt high in IDLE means an empty pop was just granted; skip the stale request.
    assign sel_pop  = pop_req && !pop_gnt && !(push_any && (pop_cnt_q == BurstMax));
    assign sel_push = push_any && !sel_pop;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr (
        .req(push_elig),
        .ptr(rr_ptr_q),
        .gnt(rr_gnt),
        .idx(rr_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q           <= StBoot;
            rr_ptr_q          <= '0;
            pop_cnt_q         <= '0;
            is_pop_q          <= 1'b0;
            push_gnt          <= '0;
            pop_gnt           <= 1'b0;
            pop_valid         <= 1'b0;
            pop_empty         <= 1'b0;
            pop_vertex        <= '0;
            pop_prev          <= '0;
            pop_dist          <= '0;
            overflow_err      <= 1'b0;
            pq.pq_op_en       <= 1'b0;
            pq.pq_opcode      <= 1'b0;
            pq.pq_vertex      <= '0;
            pq.pq_prev_vertex <= '0;
            pq.pq_dist        <= '0;
        end else begin
            push_gnt    <= '0;
            pop_gnt     <= 1'b0;
            pop_valid   <= 1'b0;
            pop_empty   <= 1'b0;
            pq.pq_op_en <= 1'b0;

            if (err_clr) begin
                overflow_err <= 1'b0;
            end else if (full && (|push_req)) begin
                overflow_err <= 1'b1;
            end

            unique case (state_q)
                StBoot: state_q <= StIdle;
                StIdle: begin
                    if (sel_pop) begin
                        pop_gnt <= 1'b1;
                        if ((|push_req) && (pop_cnt_q != BurstMax)) begin
                            pop_cnt_q <= pop_cnt_q + 1'b1;
                        end
                        if (pq.pq_queue_length == 16'd0) begin
                            pop_valid <= 1'b1;
                            pop_empty <= 1'b1;
                        end else begin
                            state_q      <= StIssue;
                            is_pop_q     <= 1'b1;
                            pq.pq_op_en  <= 1'b1;
                            pq.pq_opcode <= PQ_POP;
                        end
                    end else if (sel_push) begin
                        state_q           <= StIssue;
                        is_pop_q          <= 1'b0;
                        push_gnt          <= rr_gnt;
                        pop_cnt_q         <= '0;
                        rr_ptr_q          <= (rr_idx == LastIdx) ? '0 : rr_idx + 1'b1;
                        pq.pq_op_en       <= 1'b1;
                        pq.pq_opcode      <= PQ_PUSH;
                        pq.pq_vertex      <= push_vertex[32'(rr_idx) * W +: W];
                        pq.pq_prev_vertex <= push_prev[32'(rr_idx) * W +: W];
                        pq.pq_dist        <= push_dist[32'(rr_idx) * W +: W];
                    end
                end
                StIssue: begin
                    state_q      <= StExec;
                    pq.pq_opcode <= PQ_POP;
                end
                StExec: state_q <= StDone;
                StDone: begin
                    state_q <= StIdle;
                    if (is_pop_q) begin
                        pop_valid  <= 1'b1;
                        pop_vertex <= pq.pq_discard_vertex;
                        pop_prev   <= pq.pq_discard_prev;
                        pop_dist   <= pq.pq_discard_dist;
                    end
                end
                default: state_q <= StBoot;
            endcase
        end
    end

endmodule
